// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module   : fp_round_pack
//  Purpose  : Final stage of the 12-bit two's-complement to 8-bit float
//             converter. Derives the 3-bit exponent and the round bit from the
//             11-bit magnitude, rounds half-up (or truncates), saturates on
//             overflow and packs {sign, exp[2:0], frac[3:0]}.
//             Two-stage valid/ready pipeline with full backpressure, plus a
//             saturating count of saturated results delivered.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             in_valid   - upstream sample valid
//             in_ready   - sample accepted this cycle
//             sign_in    - sign of the original sample (1 = negative)
//             mag_in     - 11-bit magnitude
//             frac_in    - 4 bits following the leading one of mag_in
//             sat_in     - upstream overflow, forces a saturated result
//             out_valid  - packed float valid
//             out_ready  - downstream accepts the float
//             float_out  - {sign, exp[2:0], frac[3:0]}
//             sat_flag   - float_out is saturated (qualified by out_valid)
//             sat_count  - number of saturated results delivered
//  Revision : 1.0 - initial release
// ============================================================================
module fp_round_pack #(
    parameter bit ROUND_EN = 1'b1,
    parameter int SATCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sign_in,
    input  logic [10:0]         mag_in,
    input  logic [3:0]          frac_in,
    input  logic                sat_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          float_out,
    output logic                sat_flag,
    output logic [SATCNT_W-1:0] sat_count
);

    localparam logic [SATCNT_W-1:0] c_SATCNT_MAX = '1;
    localparam logic [6:0]          c_SAT_BODY   = 7'h7F;

    // ------------------------------------------------------------------
    // Stage 1 combinational: leading-one position, exponent, round bit
    // ------------------------------------------------------------------
    logic [3:0] w_lead;     // index of leading one, 0 when mag_in < 16
    logic [2:0] w_exp;
    logic       w_round;

    always_comb begin
        w_lead = 4'd0;
        for (int i = 4; i <= 10; i++) begin
            if (mag_in[i]) begin
                w_lead = 4'(i);
            end
        end
    end

    assign w_exp = (w_lead == 4'd0) ? 3'd0 : 3'(w_lead - 4'd3);

    // Round bit sits just below the 4 fraction bits; none exists for p <= 4.
    always_comb begin
        w_round = 1'b0;
        if (ROUND_EN) begin
            for (int i = 5; i <= 10; i++) begin
                if (w_lead == 4'(i)) begin
                    w_round = mag_in[i-5];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r1_valid;
    logic r2_valid;
    logic w_s2_ready;

    assign w_s2_ready = !r2_valid || out_ready;
    assign in_ready   = !r1_valid || w_s2_ready;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic       r1_sign;
    logic [3:0] r1_frac;
    logic       r1_sat;
    logic [2:0] r1_exp;
    logic       r1_round;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_frac  <= 4'd0;
            r1_sat   <= 1'b0;
            r1_exp   <= 3'd0;
            r1_round <= 1'b0;
        end else if (in_ready) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_sign  <= sign_in;
                r1_frac  <= frac_in;
                r1_sat   <= sat_in;
                r1_exp   <= w_exp;
                r1_round <= w_round;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: round, exponent carry, saturation, pack
    // ------------------------------------------------------------------
    logic [4:0] w_sum;
    logic [3:0] w_exp_inc;
    logic       w_sat;
    logic [7:0] w_float;

    assign w_sum     = {1'b0, r1_frac} + {4'd0, r1_round};
    // A fraction carry-out (sum of 16) leaves frac = 0 and bumps the exponent.
    assign w_exp_inc = {1'b0, r1_exp} + {3'd0, w_sum[4]};
    assign w_sat     = r1_sat || w_exp_inc[3];
    assign w_float   = w_sat ? {r1_sign, c_SAT_BODY}
                             : {r1_sign, w_exp_inc[2:0], w_sum[3:0]};

    // ------------------------------------------------------------------
    // Stage 2 registers (output)
    // ------------------------------------------------------------------
    logic [7:0]          r2_float;
    logic                r2_sat;
    logic [SATCNT_W-1:0] r_sat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_float <= 8'h00;
            r2_sat   <= 1'b0;
        end else if (w_s2_ready) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_float <= w_float;
                r2_sat   <= w_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (r2_valid && out_ready && r2_sat && (r_sat_count != c_SATCNT_MAX)) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

    assign out_valid = r2_valid;
    assign float_out = r2_float;
    assign sat_flag  = r2_sat;
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire
